// File: rtl/scalar_mul_engine.sv
// Scalar x matrix multiply engine. It captures an m x n unsigned matrix and a scalar,
// then writes one scaled element per clock in row-major order. Each product either
// saturates or truncates to ELEM_W bits, and any product that does not fit sets the
// sticky overflow flag.
module scalar_mul_engine #(
    parameter int unsigned MAX_DIM  = 5,
    parameter int unsigned ELEM_W   = 8,
    parameter int unsigned SCALAR_W = 4,
    parameter int unsigned DIM_W    = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [DIM_W-1:0]                    m,
    input  logic [DIM_W-1:0]                    n,
    input  logic [SCALAR_W-1:0]                 scalar,
    input  logic                                sat_en,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrix_in,
    output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrix_out,
    output logic                                busy,
    output logic                                done,
    output logic                                valid,
    output logic                                dim_err,
    output logic                                overflow
);

    localparam int unsigned NUM_ELEM = MAX_DIM * MAX_DIM;
    localparam int unsigned MAT_W    = NUM_ELEM * ELEM_W;
    localparam int unsigned PROD_W   = ELEM_W + SCALAR_W;
    localparam int unsigned IDX_W    = $clog2(NUM_ELEM + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [DIM_W-1:0]      m_q, m_d, n_q, n_d;
    logic [DIM_W-1:0]      row_q, row_d, col_q, col_d;
    logic [SCALAR_W-1:0]   scalar_q, scalar_d;
    logic                  sat_q, sat_d;
    logic [MAT_W-1:0]      mat_q, mat_d;
    logic [MAT_W-1:0]      out_q, out_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  dim_err_q, dim_err_d;
    logic                  ovf_q, ovf_d;

    logic                  dims_ok;
    logic                  last_elem;
    logic                  last_col;
    logic [IDX_W-1:0]      elem_idx;
    logic [ELEM_W-1:0]     operand;
    logic [PROD_W-1:0]     product;
    logic                  prod_ovf;
    logic [ELEM_W-1:0]     result;

    assign dims_ok   = (m != '0) && (n != '0) &&
                       (m <= DIM_W'(MAX_DIM)) && (n <= DIM_W'(MAX_DIM));
    assign last_col  = (col_q == n_q - DIM_W'(1));
    assign last_elem = last_col && (row_q == m_q - DIM_W'(1));
    assign elem_idx  = IDX_W'(row_q) * IDX_W'(MAX_DIM) + IDX_W'(col_q);

    // Select the captured element addressed by the current row/column.
    always_comb begin
        operand = '0;
        for (int unsigned p = 0; p < NUM_ELEM; p++) begin
            if (elem_idx == IDX_W'(p)) begin
                operand = mat_q[p*ELEM_W +: ELEM_W];
            end
        end
    end

    // The product is formed at full width, so overflow is just a set upper bit.
    assign product  = PROD_W'(operand) * PROD_W'(scalar_q);
    assign prod_ovf = |product[PROD_W-1:ELEM_W];
    assign result   = (prod_ovf && sat_q) ? {ELEM_W{1'b1}} : product[ELEM_W-1:0];

    // Next-state logic: accept requests in idle and write one element per cycle in run.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        n_d       = n_q;
        row_d     = row_q;
        col_d     = col_q;
        scalar_d  = scalar_q;
        sat_d     = sat_q;
        mat_d     = mat_q;
        out_d     = out_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        dim_err_d = dim_err_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d       = m;
                    n_d       = n;
                    scalar_d  = scalar;
                    sat_d     = sat_en;
                    mat_d     = matrix_in;
                    out_d     = '0;
                    valid_d   = 1'b0;
                    dim_err_d = 1'b0;
                    ovf_d     = 1'b0;
                    row_d     = '0;
                    col_d     = '0;
                    if (dims_ok) begin
                        state_d = StRun;
                    end else begin
                        // A bad request completes at once, with no result.
                        dim_err_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
            end
            StRun: begin
                for (int unsigned p = 0; p < NUM_ELEM; p++) begin
                    if (elem_idx == IDX_W'(p)) begin
                        out_d[p*ELEM_W +: ELEM_W] = result;
                    end
                end
                if (prod_ovf) begin
                    ovf_d = 1'b1;
                end
                if (last_elem) begin
                    state_d = StIdle;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                end else if (last_col) begin
                    col_d = '0;
                    row_d = row_q + DIM_W'(1);
                end else begin
                    col_d = col_q + DIM_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            m_q       <= '0;
            n_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            scalar_q  <= '0;
            sat_q     <= 1'b0;
            mat_q     <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            dim_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            n_q       <= n_d;
            row_q     <= row_d;
            col_q     <= col_d;
            scalar_q  <= scalar_d;
            sat_q     <= sat_d;
            mat_q     <= mat_d;
            out_q     <= out_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            dim_err_q <= dim_err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign matrix_out = out_q;
    assign busy       = (state_q == StRun);
    assign done       = done_q;
    assign valid      = valid_q;
    assign dim_err    = dim_err_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/scalar_mul_engine.md
SCALAR_MUL_ENGINE -- requirements
Module: scalar_mul_engine

Interface
REQ-001 The block SHALL have parameter MAX_DIM, default 5, meaning the maximum row/column count.
REQ-002 The block SHALL have parameter ELEM_W, default 8, meaning the unsigned element width.
REQ-003 The block SHALL have parameter SCALAR_W, default 4, meaning the unsigned scalar width.
REQ-004 The block SHALL have parameter DIM_W, default 3, meaning the m/n port width (must hold MAX_DIM+1).
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request; sampled only in IDLE.
REQ-008 m  input  DIM_W  row count.
REQ-009 n  input  DIM_W  column count.
REQ-010 scalar  input  SCALAR_W  multiplier.
REQ-011 sat_en  input  1  1 = saturate, 0 = truncate.
REQ-012 matrix_in  input  MAX_DIM*MAX_DIM*ELEM_W  element (r,c) at bits [(r*MAX_DIM+c)*ELEM_W +: ELEM_W].
REQ-013 matrix_out  output  MAX_DIM*MAX_DIM*ELEM_W  result, same packing.
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 valid  output  1  level; matrix_out holds a complete result.
REQ-017 dim_err  output  1  level; last request had illegal dimensions.
REQ-018 overflow  output  1  level; at least one product exceeded ELEM_W bits.

Function
REQ-019 The block SHALL implement states IDLE and RUN; a start sampled in IDLE is accepted at that edge (E0).
REQ-020 On acceptance the block SHALL capture m, n, scalar, sat_en and matrix_in, and clear matrix_out, valid, dim_err, overflow.
REQ-021 If m or n is 0 or greater than MAX_DIM at E0, the block SHALL remain in IDLE, set dim_err=1, valid=0, and pulse done after E0.
REQ-022 Otherwise the block SHALL enter RUN (busy=1 after E0) and write one element per edge, row-major, element k at edge E(k+1), k=0..m*n-1.
REQ-023 Each product SHALL be computed unsigned at full ELEM_W+SCALAR_W width.
REQ-024 A product above 2^ELEM_W-1 SHALL set overflow (sticky until next acceptance) and write 2^ELEM_W-1 when sat_en=1, else its low ELEM_W bits.
REQ-025 Elements outside the m x n region SHALL read zero.
REQ-026 At edge E(m*n) the block SHALL return to IDLE with busy=0, valid=1 and done=1 for exactly one cycle.
REQ-027 start while busy=1 SHALL be ignored; start in the cycle done=1 SHALL be accepted.
REQ-028 Inputs changing during RUN SHALL NOT affect the result.

Reset
REQ-029 reset=1 SHALL immediately force IDLE and zero matrix_out, busy, done, valid, dim_err, overflow, including mid-RUN.
REQ-030 After reset release the first accepted start SHALL behave as REQ-019..REQ-026.

Verification
REQ-031 m=2,n=3,scalar=3,sat_en=0, rows {1,2,3},{3,4,5} -> {3,6,9},{9,12,15}, done at E6, overflow=0, other elements 0.
REQ-032 m=1,n=2,scalar=15, {200,17}: sat_en=1 -> {255,255}, overflow=1; sat_en=0 -> {184,255}, overflow=1.
REQ-033 m=0,n=3 and m=6,n=2 -> dim_err=1, valid=0, done after E0, busy never set, matrix_out all zero.
REQ-034 m=n=5, all elements 0xFF, scalar=1 -> output equals input, done at E25, overflow=0; start pulses during RUN ignored.
REQ-035 reset asserted at E3 of a 2x3 run -> all outputs 0 asynchronously; subsequent 2x3 run matches REQ-031.
REQ-036 start held high across done -> second request accepted on done cycle, valid drops, new result correct.
